// File: rtl/dmi_bridge_buffered.sv
// Buffered host-to-DMI bridge: a small request FIFO feeding a single-outstanding
// DM transaction engine with a WAIT-state timeout and stale-response accounting.
module dmi_bridge_buffered #(
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [31:0]       host_req_data,
  input  logic [1:0]        host_req_op,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [31:0]       host_rsp_data,
  output logic [1:0]        host_rsp_response,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_valid,
  output logic              dmi_rsp_ready,
  input  logic [31:0]       dmi_rsp_data,
  input  logic [1:0]        dmi_rsp_response,
  output logic [15:0]       timeout_count,
  output logic [15:0]       dropped_count,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [31:0]       r_fifo_data [DEPTH];
  logic [1:0]        r_fifo_op   [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_full, w_empty, w_push, w_pop;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_op;
  logic [31:0]       r_rsp_data;
  logic [1:0]        r_rsp_resp;
  logic [CW-1:0]     r_wcnt;
  logic [15:0]       r_to_cnt, r_drop_cnt;
  logic              w_timeout, w_dmi_req_valid, w_host_rsp_valid;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = host_req_valid && host_req_ready;
  assign w_timeout = (TIMEOUT != 0) && (r_wcnt == CW'(TIMEOUT - 1));

  // Storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= host_req_addr;
      r_fifo_data[r_wr_ptr] <= host_req_data;
      r_fifo_op[r_wr_ptr]   <= host_req_op;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_pop            = 1'b0;
    w_dmi_req_valid  = 1'b0;
    w_host_rsp_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = (r_fifo_op[r_rd_ptr] != 2'd0) ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        w_dmi_req_valid = 1'b1;
        if (dmi_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        // A response in the timeout cycle takes priority over the timeout.
        if (dmi_rsp_valid || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        w_host_rsp_valid = 1'b1;
        if (host_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_op       <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
      r_wcnt     <= '0;
      r_to_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      // A popped NOP goes straight to RESP, so clearing the response here yields 0/0.
      if (w_pop) begin
        r_addr     <= r_fifo_addr[r_rd_ptr];
        r_data     <= r_fifo_data[r_rd_ptr];
        r_op       <= r_fifo_op[r_rd_ptr];
        r_rsp_data <= '0;
        r_rsp_resp <= '0;
      end
      if (r_state == S_ISSUE && dmi_req_ready)
        r_wcnt <= '0;
      else if (r_state == S_WAIT && TIMEOUT != 0)
        r_wcnt <= r_wcnt + CW'(1);
      if (r_state == S_WAIT && dmi_rsp_valid) begin
        r_rsp_data <= dmi_rsp_data;
        r_rsp_resp <= dmi_rsp_response;
      end else if (r_state == S_WAIT && w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_resp <= 2'd2;
        if (r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (dmi_rsp_valid && r_state != S_WAIT && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign host_req_ready    = RST_N && !w_full;
  assign dmi_rsp_ready     = RST_N;
  assign dmi_req_valid     = RST_N && w_dmi_req_valid;
  assign host_rsp_valid    = RST_N && w_host_rsp_valid;
  assign dmi_req_addr      = RST_N ? r_addr     : '0;
  assign dmi_req_data      = RST_N ? r_data     : '0;
  assign dmi_req_op        = RST_N ? r_op       : '0;
  assign host_rsp_data     = RST_N ? r_rsp_data : '0;
  assign host_rsp_response = RST_N ? r_rsp_resp : '0;
  assign timeout_count     = RST_N ? r_to_cnt   : '0;
  assign dropped_count     = RST_N ? r_drop_cnt : '0;
  assign busy              = RST_N && ((r_state != S_IDLE) || !w_empty);

endmodule

// File: tb/tb_dmi_bridge_buffered.sv
// Scoreboard bench for dmi_bridge_buffered: directed stimulus pushes expected
// DM requests and host responses; a negedge monitor pops and compares them.
module tb_dmi_bridge_buffered;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  logic [6:0]  host_req_addr = '0;
  logic [31:0] host_req_data = '0;
  logic [1:0]  host_req_op = '0;
  logic        host_rsp_valid;
  logic        host_rsp_ready = 1'b0;
  logic [31:0] host_rsp_data;
  logic [1:0]  host_rsp_response;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid = 1'b0;
  logic        dmi_rsp_ready;
  logic [31:0] dmi_rsp_data = '0;
  logic [1:0]  dmi_rsp_response = '0;
  logic [15:0] timeout_count, dropped_count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_dmi[$];
  logic [63:0] exp_host[$];
  logic [63:0] e_d, e_h;

  dmi_bridge_buffered #(.ADDR_W(7), .DEPTH(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_addr(host_req_addr), .host_req_data(host_req_data), .host_req_op(host_req_op),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_data(host_rsp_data), .host_rsp_response(host_rsp_response),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_response(dmi_rsp_response),
    .timeout_count(timeout_count), .dropped_count(dropped_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    tests++;
    fails++;
    $display("FAIL %s wait bound expired", nm);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    bit ok = 0;
    host_req_valid = 1'b1; host_req_addr = a; host_req_data = d; host_req_op = op;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (host_req_ready) ok = 1;
    end
    if (!ok) tmo("push");
    tick();
    host_req_valid = 1'b0;
  endtask

  // Wait for the DM request handshake, then answer one cycle into WAIT.
  task automatic serve(input logic [31:0] d, input logic [1:0] r);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (dmi_req_valid && dmi_req_ready) ok = 1;
    end
    if (!ok) tmo("serve");
    tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_data = d; dmi_rsp_response = r;
    tick();
    dmi_rsp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (!busy) ok = 1;
    end
    if (!ok) tmo(nm);
    tick();
  endtask

  function automatic logic [63:0] dq(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'd0, a, d, op};
  endfunction

  function automatic logic [63:0] hq(input logic [31:0] d, input logic [1:0] r);
    return {30'd0, d, r};
  endfunction

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (dmi_req_valid && dmi_req_ready) begin
        if (exp_dmi.size() == 0) begin
          tests++; fails++;
          $display("FAIL dmi_req unexpected actual=%h", dq(dmi_req_addr, dmi_req_data, dmi_req_op));
        end else begin
          e_d = exp_dmi.pop_front();
          chk("dmi_req", dq(dmi_req_addr, dmi_req_data, dmi_req_op), e_d);
        end
      end
      if (host_rsp_valid && host_rsp_ready) begin
        if (exp_host.size() == 0) begin
          tests++; fails++;
          $display("FAIL host_rsp unexpected actual=%h", hq(host_rsp_data, host_rsp_response));
        end else begin
          e_h = exp_host.pop_front();
          chk("host_rsp", hq(host_rsp_data, host_rsp_response), e_h);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_host_req_ready", host_req_ready, 0);
    chk("rst_dmi_rsp_ready", dmi_rsp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {host_rsp_valid, dmi_req_valid}, 0);
    chk("rst_counters", {timeout_count, dropped_count}, 0);
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_readies", {host_req_ready, dmi_rsp_ready, busy}, 3'b110);
    tick();

    // Single read with latency checks
    host_rsp_ready = 1'b1; dmi_req_ready = 1'b1;
    exp_dmi.push_back(dq(7'h11, 32'h0, 2'd1));
    exp_host.push_back(hq(32'hCAFE0001, 2'd0));
    push(7'h11, 32'h0, 2'd1);
    @(negedge CLK); chk("rd_req_n1", dmi_req_valid, 0);
    @(negedge CLK); chk("rd_req_n2", dmi_req_valid, 1);
    tick(); tick(); tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hCAFE0001; dmi_rsp_response = 2'd0;
    @(negedge CLK); chk("rd_rsp_m", host_rsp_valid, 0);
    tick();
    dmi_rsp_valid = 1'b0;
    @(negedge CLK); chk("rd_rsp_m1", host_rsp_valid, 1);
    tick();
    wait_idle("rd_idle");

    // NOP: no DM access, response two cycles after accept
    exp_host.push_back(hq(32'h0, 2'd0));
    push(7'h05, 32'h123, 2'd0);
    @(negedge CLK); chk("nop_n1", host_rsp_valid, 0);
    @(negedge CLK); chk("nop_n2", host_rsp_valid, 1);
    tick();
    wait_idle("nop_idle");

    // Back-to-back fill with DM stalled, then drain in order
    dmi_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_dmi.push_back(dq(7'h20 + 7'(i), 32'h1000_0000 + 32'(i), (i % 2) ? 2'd2 : 2'd1));
      exp_host.push_back(hq(32'hD000_0000 + 32'(i), 2'(i % 2)));
      push(7'h20 + 7'(i), 32'h1000_0000 + 32'(i), (i % 2) ? 2'd2 : 2'd1);
    end
    @(negedge CLK);
    chk("full_ready", host_req_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_issue_head", dq(dmi_req_addr, dmi_req_data, dmi_req_op), dq(7'h20, 32'h1000_0000, 2'd1));
    tick();
    dmi_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) serve(32'hD000_0000 + 32'(i), 2'(i % 2));
    wait_idle("fill_idle");
    @(negedge CLK); chk("drained_ready", host_req_ready, 1);
    tick();

    // Timeout, late response dropped, next request unaffected
    exp_dmi.push_back(dq(7'h03, 32'h0, 2'd1));
    exp_host.push_back(hq(32'h0, 2'd2));
    push(7'h03, 32'h0, 2'd1);
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge CLK);
        if (dmi_req_valid) ok = 1;
      end
      if (!ok) tmo("to_issue");
    end
    tick();
    repeat (7) tick();
    @(negedge CLK); chk("to_w7", host_rsp_valid, 0);
    tick();
    @(negedge CLK);
    chk("to_w8", host_rsp_valid, 1);
    chk("to_count", timeout_count, 16'd1);
    tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hDEAD_BEEF; dmi_rsp_response = 2'd0;
    tick();
    dmi_rsp_valid = 1'b0;
    @(negedge CLK);
    chk("late_dropped", dropped_count, 16'd1);
    tick();
    exp_dmi.push_back(dq(7'h04, 32'h77, 2'd2));
    exp_host.push_back(hq(32'h55, 2'd0));
    push(7'h04, 32'h77, 2'd2);
    serve(32'h55, 2'd0);
    wait_idle("after_to_idle");

    // Response in the same cycle as the timeout wins
    exp_dmi.push_back(dq(7'h06, 32'h9, 2'd1));
    exp_host.push_back(hq(32'h0BAD_F00D, 2'd0));
    push(7'h06, 32'h9, 2'd1);
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge CLK);
        if (dmi_req_valid) ok = 1;
      end
      if (!ok) tmo("race_issue");
    end
    tick();
    repeat (7) tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h0BAD_F00D; dmi_rsp_response = 2'd0;
    tick();
    dmi_rsp_valid = 1'b0;
    @(negedge CLK);
    chk("race_valid", host_rsp_valid, 1);
    chk("race_to_count", timeout_count, 16'd1);
    chk("race_drop_count", dropped_count, 16'd1);
    tick();
    wait_idle("race_idle");

    // Host response backpressure; FIFO keeps filling
    host_rsp_ready = 1'b0;
    exp_dmi.push_back(dq(7'h30, 32'h1, 2'd1));
    exp_host.push_back(hq(32'hAAAA5555, 2'd0));
    push(7'h30, 32'h1, 2'd1);
    serve(32'hAAAA5555, 2'd0);
    for (int i = 0; i < 4; i++) begin
      exp_host.push_back(hq(32'h0, 2'd0));
      push(7'h40 + 7'(i), 32'h0, 2'd0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp_hold", {host_rsp_valid, dmi_req_valid, host_req_ready, host_rsp_data},
          {1'b1, 1'b0, 1'b0, 32'hAAAA5555});
      tick();
    end
    host_rsp_ready = 1'b1;
    wait_idle("bp_idle");

    // Reset during WAIT with two requests queued
    exp_dmi.push_back(dq(7'h50, 32'h2, 2'd1));
    push(7'h50, 32'h2, 2'd1);
    begin
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge CLK);
        if (dmi_req_valid) ok = 1;
      end
      if (!ok) tmo("rst_issue");
    end
    tick();
    dmi_req_ready = 1'b0;
    push(7'h51, 32'h3, 2'd1);
    push(7'h52, 32'h4, 2'd0);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_outs", {host_req_ready, dmi_rsp_ready, dmi_req_valid, host_rsp_valid, busy}, 0);
    chk("midrst_counters", {timeout_count, dropped_count}, 0);
    tick(); tick();
    RST_N = 1'b1;
    dmi_req_ready = 1'b1;
    @(negedge CLK);
    chk("after_rst_busy", busy, 0);
    repeat (5) tick();
    @(negedge CLK);
    chk("after_rst_quiet", {busy, dmi_req_valid, host_rsp_valid}, 0);
    tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h1; dmi_rsp_response = 2'd0;
    tick();
    dmi_rsp_valid = 1'b0;
    @(negedge CLK);
    chk("after_rst_dropped", dropped_count, 16'd1);
    tick();

    chk("sb_dmi_empty", 64'(exp_dmi.size()), 0);
    chk("sb_host_empty", 64'(exp_host.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
